// File: rtl/gpu_pixel_writer_pkg.sv
// Shared geometry, framebuffer constants and FSM encoding for the pixel writer slice.
// The GPU_PIXEL_CLIP_EN build macro is consumed by gpu_pixel_writer.
package gpu_pixel_writer_pkg;

    localparam int GPU_WIDTH_BITS    = 10;
    localparam int GPU_HEIGHT_BITS   = 9;
    localparam int GPU_SCREEN_WIDTH  = 640;
    localparam int GPU_SCREEN_HEIGHT = 480;
    localparam int GPU_COLOR_BITS    = 8;
    localparam int GPU_FB_ADDR_BITS  = 19;
    localparam int GPU_FIFO_DEPTH    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } wr_state_e;

endpackage

// File: rtl/gpu_pixel_fifo.sv
// Synchronous FIFO buffering pixel entries; DEPTH must be a power of two so the
// pointers wrap naturally.
module gpu_pixel_fifo
    import gpu_pixel_writer_pkg::*;
#(
    parameter int DATA_W = 28,
    parameter int DEPTH  = GPU_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push, do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count/pointers gate every read, so stale data is never used.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/gpu_pixel_writer.sv
// Pixel stream consumer: buffers (x,y,color,last) pixels and writes them to the
// framebuffer over req/ack. Define GPU_PIXEL_CLIP_EN to discard off-screen pixels.
module gpu_pixel_writer
    import gpu_pixel_writer_pkg::*;
#(
    parameter int WIDTH_BITS    = GPU_WIDTH_BITS,
    parameter int HEIGHT_BITS   = GPU_HEIGHT_BITS,
    parameter int SCREEN_WIDTH  = GPU_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = GPU_SCREEN_HEIGHT,
    parameter int COLOR_BITS    = GPU_COLOR_BITS,
    parameter int ADDR_BITS     = GPU_FB_ADDR_BITS,
    parameter int FIFO_DEPTH    = GPU_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    input  logic [WIDTH_BITS-1:0]  pix_x,
    input  logic [HEIGHT_BITS-1:0] pix_y,
    input  logic [COLOR_BITS-1:0]  pix_color,
    input  logic                   pix_last,
    output logic                   mem_req,
    output logic [ADDR_BITS-1:0]   mem_addr,
    output logic [COLOR_BITS-1:0]  mem_data,
    input  logic                   mem_ack,
    output logic                   busy,
    output logic                   done
);

    localparam int ENTRY_W = WIDTH_BITS + HEIGHT_BITS + COLOR_BITS + 1;
`ifdef GPU_PIXEL_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    wr_state_e               state_q, state_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic [COLOR_BITS-1:0]   data_q, data_d;
    logic                    last_q, last_d;

    logic                    fifo_full, fifo_empty, fifo_pop, take_head;
    logic [ENTRY_W-1:0]      head;
    logic [WIDTH_BITS-1:0]   head_x;
    logic [HEIGHT_BITS-1:0]  head_y;
    logic [COLOR_BITS-1:0]   head_color;
    logic                    head_last, head_clip;
    logic [ADDR_BITS-1:0]    head_addr;

    gpu_pixel_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .push    (pix_valid),
        .wr_data ({pix_x, pix_y, pix_color, pix_last}),
        .pop     (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign {head_x, head_y, head_color, head_last} = head;

    // Linear framebuffer address; anything beyond ADDR_BITS is silently dropped.
    assign head_addr = ADDR_BITS'(32'(head_y) * 32'(SCREEN_WIDTH) + 32'(head_x));
    assign head_clip = CLIP_EN && ((32'(head_x) >= 32'(SCREEN_WIDTH)) ||
                                   (32'(head_y) >= 32'(SCREEN_HEIGHT)));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        last_d    = last_q;
        take_head = 1'b0;
        case (state_q)
            ST_IDLE: take_head = !fifo_empty;
            ST_REQ: begin
                if (mem_ack) begin
                    if (last_q)           state_d   = ST_DONE;
                    else if (!fifo_empty) take_head = 1'b1;
                    else                  state_d   = ST_IDLE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Popping in REQ on the ack cycle gives back-to-back single-beat writes.
        fifo_pop = take_head;
        if (take_head) begin
            if (head_clip) begin
                state_d = head_last ? ST_DONE : ST_IDLE;
            end else begin
                state_d = ST_REQ;
                addr_d  = head_addr;
                data_d  = head_color;
                last_d  = head_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign pix_ready = !fifo_full;
    assign mem_req   = (state_q == ST_REQ);
    assign mem_addr  = addr_q;
    assign mem_data  = data_q;
    assign done      = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Self-checking bench for gpu_pixel_writer: directed steps plus randomized streams
// scored against a queue-based model of the framebuffer writes.
module tb_gpu_pixel_writer;

    localparam int WB = 10;
    localparam int HB = 9;
    localparam int CB = 8;
    localparam int AB = 19;
    localparam int SW = 640;
    localparam int SH = 480;

    typedef struct {
        int x;
        int y;
        int c;
        bit last;
    } pix_t;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          pix_valid;
    logic          pix_ready;
    logic [WB-1:0] pix_x;
    logic [HB-1:0] pix_y;
    logic [CB-1:0] pix_color;
    logic          pix_last;
    logic          mem_req;
    logic [AB-1:0] mem_addr;
    logic [CB-1:0] mem_data;
    logic          mem_ack;
    logic          busy;
    logic          done;

    pix_t src_q[$];
    wr_t  exp_q[$];

    int n_asserts = 0;
    int n_fail    = 0;
    int exp_dones, obs_dones, obs_writes, bp_accepts;
    logic bp_ready;

    gpu_pixel_writer dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_color (pix_color),
        .pix_last  (pix_last),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_clipped(input pix_t p);
`ifdef GPU_PIXEL_CLIP_EN
        return (p.x >= SW) || (p.y >= SH);
`else
        return (p.x < 0);
`endif
    endfunction

    function automatic int fb_addr(input pix_t p);
        return (p.y * SW + p.x) % (1 << AB);
    endfunction

    task automatic drive_pix(input int x, input int y, input int c, input bit last);
        pix_valid = 1'b1;
        pix_x     = WB'(x);
        pix_y     = HB'(y);
        pix_color = CB'(c);
        pix_last  = last;
    endtask

    // Streams src_q into the DUT; acks are withheld for the first stall_len cycles.
    task automatic run_stream(input int valid_pct, input int ack_pct, input int stall_len,
                              input int budget);
        int   cyc;
        int   accepts;
        bit   accepted;
        bit   prev_wait;
        logic [AB-1:0] prev_addr;
        pix_t p;
        wr_t  w;
        cyc = 0; accepts = 0; accepted = 0; prev_wait = 0; prev_addr = '0;
        obs_dones = 0; obs_writes = 0; exp_dones = 0; bp_accepts = 0; bp_ready = 1'b1;
        foreach (src_q[i]) if (src_q[i].last) exp_dones++;
        pix_valid = 1'b0;
        while (cyc < budget) begin
            if (done === 1'b1) obs_dones++;
            if (prev_wait) begin
                check("req_held", mem_req, 1);
                check("addr_held", mem_addr, prev_addr);
            end
            if (cyc == stall_len) begin
                bp_accepts = accepts;
                bp_ready   = pix_ready;
            end
            if (accepted) pix_valid = 1'b0;
            if (!pix_valid && src_q.size() > 0 && $urandom_range(99) < valid_pct)
                drive_pix(src_q[0].x, src_q[0].y, src_q[0].c, src_q[0].last);
            if (src_q.size() == 0 && !pix_valid && exp_q.size() == 0 && busy === 1'b0)
                break;
            mem_ack = (cyc < stall_len) ? 1'b0 : ($urandom_range(99) < ack_pct);
            if (mem_req === 1'b1 && mem_ack) begin
                obs_writes++;
                check("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check("wr_addr", mem_addr, w.addr);
                    check("wr_data", mem_data, w.data);
                end
            end
            accepted = pix_valid && (pix_ready === 1'b1);
            if (accepted) begin
                p = src_q.pop_front();
                accepts++;
                if (!is_clipped(p)) exp_q.push_back('{fb_addr(p), p.c});
            end
            prev_wait = (mem_req === 1'b1) && !mem_ack;
            prev_addr = mem_addr;
            tick();
            cyc++;
        end
        pix_valid = 1'b0;
        mem_ack   = 1'b0;
        check("stream_drained", src_q.size() + exp_q.size(), 0);
        check("stream_idle", busy, 0);
        check("done_count", obs_dones, exp_dones);
    endtask

    initial begin
        n_rst = 1'b0; mem_ack = 1'b0;
        drive_pix(5, 5, 8'h11, 1'b1);

        // Reset with a pixel offered: nothing may be captured.
        tick(); tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        n_rst = 1'b1;
        pix_valid = 1'b0;
        tick();
        check("rst_pix_ready", pix_ready, 1);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_busy_after", busy, 0);

        // Single pixel, ack tied high: request two cycles after acceptance.
        mem_ack = 1'b1;
        drive_pix(9, 9, 8'hA5, 1'b1);
        tick();
        pix_valid = 1'b0;
        check("single_no_req_yet", mem_req, 0);
        check("single_busy", busy, 1);
        tick();
        check("single_req", mem_req, 1);
        check("single_addr", mem_addr, 5769);
        check("single_data", mem_data, 8'hA5);
        tick();
        check("single_done", done, 1);
        check("single_req_drop", mem_req, 0);
        tick();
        check("single_done_pulse", done, 0);
        check("single_idle", busy, 0);
        mem_ack = 1'b0;

        // Diagonal line of ten pixels with continuous ack.
        for (int i = 0; i < 10; i++) src_q.push_back('{i, i, 8'h30 + i, i == 9});
        run_stream(100, 100, 0, 200);
        check("diag_writes", obs_writes, 10);

        // Backpressure: 20 cycles without ack during an eight-pixel stream.
        for (int i = 0; i < 8; i++) src_q.push_back('{3 * i, 100 + i, 8'hC0 + i, i == 7});
        run_stream(100, 100, 20, 400);
        check("bp_accepts", bp_accepts, 5);
        check("bp_ready_low", bp_ready, 0);
        check("bp_writes", obs_writes, 8);

        // Reset while a write is outstanding.
        drive_pix(1, 2, 8'h77, 1'b0);
        tick();
        drive_pix(3, 4, 8'h78, 1'b1);
        tick();
        pix_valid = 1'b0;
        check("midrst_req_pending", mem_req, 1);
        n_rst = 1'b0;
        tick();
        check("midrst_req", mem_req, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", pix_ready, 1);
        n_rst = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_done", done, 0);
            check("midrst_no_req", mem_req, 0);
        end
        mem_ack = 1'b0;

        // Off-screen pixels: clipped when enabled, truncated-address writes otherwise.
        src_q.push_back('{700, 5, 8'h5A, 1'b0});
        src_q.push_back('{5, 500, 8'h5B, 1'b1});
        run_stream(100, 100, 0, 100);
`ifdef GPU_PIXEL_CLIP_EN
        check("clip_writes", obs_writes, 0);
`else
        check("clip_writes", obs_writes, 2);
`endif

        // Random pixels, random handshakes, several primitives back to back.
        for (int i = 0; i < 40; i++)
            src_q.push_back('{int'($urandom_range(1023)), int'($urandom_range(511)),
                              int'($urandom_range(255)),
                              (i == 39) || ($urandom_range(5) == 0)});
        run_stream(70, 60, 0, 2000);
        for (int i = 0; i < 30; i++)
            src_q.push_back('{int'($urandom_range(SW - 1)), int'($urandom_range(SH - 1)),
                              int'($urandom_range(255)),
                              (i == 29) || ($urandom_range(3) == 0)});
        run_stream(100, 35, 5, 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
